jbi_dbg_mq: RTL

Parametrised multi-channel debug capture queue for JBI. Generalises the fixed hi/lo two-queue debug block to NCH independent channels with register-file FIFOs of configurable width and depth. Each channel is time-stamped and tagged. A round-robin selector presents one 128-bit debug word to the memory-out (mout) path, with transparent, arbitrate and priority request modes and watermark/max-wait escalation.

---
 rtl/jbi_dbg_mq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/jbi_dbg_mq.sv
// jbi_dbg_mq: NCH-channel debug capture queue; round-robin readout of one 128-bit word to mout.
// Build option JBI_DBG_MQ_TSTAMP_EN stamps a wrapping 16-bit timestamp into bits [127:112].
module jbi_dbg_mq #(
    parameter int NCH    = 4,
    parameter int IN_W   = 48,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int WAIT_W = 10
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic [NCH-1:0]      dbg_in_vld,
    input  logic [NCH*IN_W-1:0] dbg_in_data,
    input  logic                csr_data_arb,
    input  logic [AW:0]         csr_hi_water,
    input  logic [AW:0]         csr_lo_water,
    input  logic [WAIT_W-1:0]   csr_max_wait,
    input  logic [15:0]         csr_tstamp_wrap,
    input  logic                csr_ovf_clr,
    input  logic                mout_dbg_pop,
    output logic                dbg_req_transparent,
    output logic                dbg_req_arbitrate,
    output logic                dbg_req_priority,
    output logic [127:0]        dbg_data,
    output logic [NCH-1:0]      dbg_ovf
);
    localparam int SW = $clog2(NCH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [IN_W-1:0]   mem_q    [NCH][DEPTH];
    logic [15:0]       ts_mem_q [NCH][DEPTH];
    logic [AW-1:0]     wr_ptr_q [NCH];
    logic [AW-1:0]     rd_ptr_q [NCH];
    logic [AW:0]       cnt_q    [NCH];
    logic [AW:0]       cnt_d    [NCH];
    logic [NCH-1:0]    ne_q, ne_d, wr_en, pop_ch, ovf_new;
    logic [NCH-1:0]    ovf_q, ovf_d;
    logic [SW-1:0]     sel_q, sel_d, cand;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              prio_q, prio_d;
    logic              any_vld, pop_eff, any_hi, all_lo, wait_hit;
    logic [15:0]       ts_q;

    // Handshake: the request (any_vld) is the valid, mout_dbg_pop is the ready; a pop
    // only transfers while a request is up, and requests never depend on the pop.
    always_comb begin
        ne_q = '0;
        for (int k = 0; k < NCH; k++) ne_q[k] = (cnt_q[k] != '0);
    end
    assign any_vld = |ne_q;
    assign pop_eff = mout_dbg_pop & any_vld;

    always_comb begin
        wr_en   = '0;
        pop_ch  = '0;
        ovf_new = '0;
        ne_d    = '0;
        any_hi  = 1'b0;
        all_lo  = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            pop_ch[k]  = pop_eff && ne_q[k] && (sel_q == SW'(k));
            wr_en[k]   = dbg_in_vld[k] && ((cnt_q[k] != FULL_CNT) || pop_ch[k]);
            ovf_new[k] = dbg_in_vld[k] && !wr_en[k];
            cnt_d[k]   = cnt_q[k] + (AW+1)'(wr_en[k]) - (AW+1)'(pop_ch[k]);
            ne_d[k]    = (cnt_d[k] != '0);
            if (cnt_q[k] >= csr_hi_water) any_hi = 1'b1;
            if (cnt_q[k] > csr_lo_water) all_lo = 1'b0;
        end
    end

    // Selector looks at next-cycle occupancy so the head shown with a fresh request is valid.
    always_comb begin
        sel_d = sel_q;
        cand  = '0;
        for (int i = NCH - 1; i >= 1; i--) begin
            cand = SW'((int'(sel_q) + i) % NCH);
            if (ne_d[cand] && (pop_eff || !ne_d[sel_q])) sel_d = cand;
        end
    end

    assign wait_hit = (csr_max_wait != '0) && (wait_q >= csr_max_wait);

    always_comb begin
        wait_d = wait_q;
        if (!any_vld || pop_eff) wait_d = '0;
        else if (wait_q != '1) wait_d = wait_q + WAIT_W'(1);
        prio_d = prio_q;
        if (any_hi || wait_hit) prio_d = 1'b1;
        else if (all_lo && (wait_q < csr_max_wait)) prio_d = 1'b0;
        ovf_d = (ovf_q & ~{NCH{csr_ovf_clr}}) | ovf_new;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int k = 0; k < NCH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            sel_q  <= '0;
            wait_q <= '0;
            prio_q <= 1'b0;
            ovf_q  <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (wr_en[k]) wr_ptr_q[k] <= wr_ptr_q[k] + AW'(1);
                if (pop_ch[k]) rd_ptr_q[k] <= rd_ptr_q[k] + AW'(1);
                cnt_q[k] <= cnt_d[k];
            end
            sel_q  <= sel_d;
            wait_q <= wait_d;
            prio_q <= prio_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is not reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (wr_en[k]) begin
                mem_q[k][wr_ptr_q[k]]    <= dbg_in_data[k*IN_W +: IN_W];
                ts_mem_q[k][wr_ptr_q[k]] <= ts_q;
            end
        end
    end

`ifdef JBI_DBG_MQ_TSTAMP_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) ts_q <= '0;
        else if (ts_q >= csr_tstamp_wrap) ts_q <= '0;
        else ts_q <= ts_q + 16'd1;
    end
`else
    logic unused_tstamp_wrap;
    assign ts_q = '0;
    assign unused_tstamp_wrap = ^csr_tstamp_wrap;
`endif

    always_comb begin
        dbg_data = '0;
        if (any_vld) begin
            dbg_data[IN_W-1:0]  = mem_q[sel_q][rd_ptr_q[sel_q]];
            dbg_data[111:104]   = 8'(sel_q);
            dbg_data[127:112]   = ts_mem_q[sel_q][rd_ptr_q[sel_q]];
        end
    end

    assign dbg_req_transparent = any_vld & ~csr_data_arb;
    assign dbg_req_arbitrate   = any_vld & csr_data_arb;
    assign dbg_req_priority    = prio_q & any_vld;
    assign dbg_ovf             = ovf_q;
endmodule
